lcd_cmd_exec: RTL and testbench
===============================

LCD_CMD_EXEC -- requirements
Module: lcd_cmd_exec

Interface
REQ-001 The block SHALL have parameter T_SU, default 2, the RS/data setup time before E rises, in clk cycles (>=1).
REQ-002 The block SHALL have parameter T_EH, default 12, the E-high pulse width, in clk cycles (>=1).
REQ-003 The block SHALL have parameter T_HD, default 2, the RS/data hold time after E falls, in clk cycles (>=1).
REQ-004 The block SHALL have parameter T_EX, default 2000, the short execution wait after a transfer, in clk cycles (>=1).
REQ-005 The block SHALL have parameter T_EXL, default 82000, the long execution wait after a transfer (clear/home), in clk cycles (>=1).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, a synchronous, active-low reset.
REQ-008 The block SHALL have port Address_in, input, 8 bits; bit7 = address phase enable, bits[6:0] = DDRAM address.
REQ-009 The block SHALL have port Control_in, input, 8 bits; bit0 = RS for the data phase, bit1 = long execution wait, bit2 = skip data phase, bits[7:3] = ignored.
REQ-010 The block SHALL have port Data_in, input, 8 bits, the data or instruction byte for the data phase.
REQ-011 The block SHALL have port cmd_valid, input, 1 bit, a one-cycle command strobe.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a command is in progress.
REQ-013 The block SHALL have port status, output, 8 bits, the count of completed commands, wrapping modulo 256.
REQ-014 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when cmd_valid arrives while busy.
REQ-015 The block SHALL have ports lcd_rs, lcd_rw and lcd_e, outputs, 1 bit each, the LCD bus control lines.
REQ-016 The block SHALL have port lcd_data, output, 8 bits, the LCD bus data.

Function
REQ-017 Command acceptance SHALL occur on a clk edge with cmd_valid=1 and busy=0. At that edge the block SHALL latch Address_in, Control_in and Data_in internally; busy SHALL be 1 from the next cycle.
REQ-018 A cmd_valid received while busy=1 SHALL be dropped, leave the latched command unchanged, and pulse overrun high for exactly one cycle.
REQ-019 The FSM states SHALL be IDLE, A_SU, A_EH, A_HD, A_EX, D_SU, D_EH, D_HD, D_EX, DONE, driven by a single down-counter reloaded on each state entry.
REQ-020 Transitions from IDLE on acceptance: to A_SU if Address_in[7]=1; else to D_SU if Control_in[2]=0; else to DONE.
REQ-021 Each xx_SU state SHALL last T_SU cycles, each xx_EH state T_EH cycles, and each xx_HD state T_HD cycles. A_EX SHALL last T_EX cycles. D_EX SHALL last T_EXL cycles if latched Control_in[1]=1, else T_EX cycles.
REQ-022 From A_EX the FSM SHALL go to D_SU if latched Control_in[2]=0, else to DONE. From D_EX it SHALL go to DONE. From DONE it SHALL go to IDLE after exactly 1 cycle.
REQ-023 During the address phase (A_*) the block SHALL drive lcd_rs=0 and lcd_data={1'b1, Address[6:0]}.
REQ-024 During the data phase (D_*) the block SHALL drive lcd_rs=latched Control_in[0] and lcd_data=latched Data_in.
REQ-025 lcd_e SHALL be 1 only in A_EH and D_EH; all outputs SHALL be registered and glitch-free.
REQ-026 lcd_rw SHALL be constant 0, since the block only writes.
REQ-027 In IDLE and DONE the block SHALL drive lcd_rs=0, lcd_data=0 and lcd_e=0.
REQ-028 In DONE, status SHALL increment by 1 (255 wraps to 0). busy SHALL be 1 in DONE and 0 in IDLE.
REQ-029 A command with Address_in[7]=0 and Control_in[2]=1 SHALL produce no E pulse and SHALL still count: busy=1 for 1 cycle (DONE) and status+1.
REQ-030 The command inputs SHALL be don't-care except on an acceptance edge.
REQ-031 Each phase SHALL occupy T_SU+T_EH+T_HD+(wait) cycles. Total busy cycles SHALL equal the sum of the executed phases plus 1 (the DONE cycle).
REQ-032 A new command SHALL be acceptable on the first cycle busy=0, giving back-to-back throughput with one IDLE cycle between commands.

Reset
REQ-033 With rst_n=0 at a clk edge, the block SHALL go to IDLE and set the counter=0, busy=0, status=0, overrun=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0. This SHALL also apply mid-command (E forced low at that edge), and the aborted command SHALL not be counted.
REQ-034 cmd_valid SHALL be ignored while rst_n=0. The first acceptance SHALL be possible on the first edge with rst_n=1.

Verification
(All scenarios use parameters T_SU=1, T_EH=2, T_HD=1, T_EX=4, T_EXL=8.)
REQ-035 Scenario 1, data only: Address=0x00, Control=0x01, Data=0x41 -> lcd_rs=1, lcd_data=0x41; one E pulse 2 cycles wide starting 1 cycle after D_SU entry; busy high 9 cycles; status 0->1.
REQ-036 Scenario 2, address then data: Address=0x85, Control=0x00, Data=0x0C -> first E pulse with lcd_rs=0, lcd_data=0x85, then E pulse with lcd_rs=0, lcd_data=0x0C; busy high 17 cycles; status +1.
REQ-037 Scenario 3, long wait: Address=0x00, Control=0x02, Data=0x01 -> busy high 13 cycles.
REQ-038 Scenario 4, skip with no address: Address=0x00, Control=0x04 -> no E pulse, busy high 1 cycle, status +1. Separately, cmd_valid during busy -> overrun pulses 1 cycle and the in-flight bytes are unchanged.
REQ-039 Scenario 5, reset mid-E: assert rst_n=0 during D_EH -> at the next edge lcd_e=0, busy=0 and status=0. After release, a new command completes normally.
REQ-040 Scenario 6, status wrap: issue 256 skip-only commands -> status returns to 0x00, with each increment occurring exactly in the DONE cycle.

Source files
------------

// File: rtl/lcd_cmd_exec.sv
// HD44780-style LCD write sequencer: optional address phase, optional data phase, then a completion count.
// Latency: busy from the cycle after acceptance; commands arriving while busy are dropped and flagged.
module lcd_cmd_exec #(
    parameter int T_SU  = 2,
    parameter int T_EH  = 12,
    parameter int T_HD  = 2,
    parameter int T_EX  = 2000,
    parameter int T_EXL = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Address_in,
    input  logic [7:0] Control_in,
    input  logic [7:0] Data_in,
    input  logic       cmd_valid,
    output logic       busy,
    output logic [7:0] status,
    output logic       overrun,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int TM1  = (T_SU > T_EH) ? T_SU : T_EH;
    localparam int TM2  = (TM1 > T_HD) ? TM1 : T_HD;
    localparam int TM3  = (TM2 > T_EX) ? TM2 : T_EX;
    localparam int TMAX = (TM3 > T_EXL) ? TM3 : T_EXL;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        IDLE, A_SU, A_EH, A_HD, A_EX, D_SU, D_EH, D_HD, D_EX, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [6:0]    addr_q, addr_nxt;
    logic [2:0]    ctrl_q, ctrl_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          accept;
    logic          phase_a, phase_d;
    logic          unused_ctrl;

    assign unused_ctrl = &{1'b0, Control_in[7:3]};
    assign lcd_rw      = 1'b0;

    // Counter holds (remaining cycles - 1) of the current state.
    function automatic logic [CW-1:0] load(input state_t s, input logic long_wait);
        case (s)
            A_SU, D_SU: load = CW'(T_SU - 1);
            A_EH, D_EH: load = CW'(T_EH - 1);
            A_HD, D_HD: load = CW'(T_HD - 1);
            A_EX:       load = CW'(T_EX - 1);
            D_EX:       load = long_wait ? CW'(T_EXL - 1) : CW'(T_EX - 1);
            default:    load = '0;
        endcase
    endfunction

    always_comb begin
        accept    = cmd_valid && (state == IDLE);
        addr_nxt  = accept ? Address_in[6:0] : addr_q;
        ctrl_nxt  = accept ? Control_in[2:0] : ctrl_q;
        data_nxt  = accept ? Data_in : data_q;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (cmd_valid) begin
                if (Address_in[7])      state_nxt = A_SU;
                else if (!Control_in[2]) state_nxt = D_SU;
                else                    state_nxt = DONE;
            end
            A_SU: if (cnt == '0) state_nxt = A_EH;
            A_EH: if (cnt == '0) state_nxt = A_HD;
            A_HD: if (cnt == '0) state_nxt = A_EX;
            A_EX: if (cnt == '0) state_nxt = ctrl_q[2] ? DONE : D_SU;
            D_SU: if (cnt == '0) state_nxt = D_EH;
            D_EH: if (cnt == '0) state_nxt = D_HD;
            D_HD: if (cnt == '0) state_nxt = D_EX;
            D_EX: if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = load(state_nxt, ctrl_nxt[1]);
        else if (cnt != '0)     cnt_nxt = cnt - CW'(1);
        phase_a = (state_nxt == A_SU) || (state_nxt == A_EH) ||
                  (state_nxt == A_HD) || (state_nxt == A_EX);
        phase_d = (state_nxt == D_SU) || (state_nxt == D_EH) ||
                  (state_nxt == D_HD) || (state_nxt == D_EX);
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            ctrl_q   <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            status   <= '0;
            overrun  <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            addr_q   <= addr_nxt;
            ctrl_q   <= ctrl_nxt;
            data_q   <= data_nxt;
            busy     <= (state_nxt != IDLE);
            overrun  <= cmd_valid && (state != IDLE);
            lcd_e    <= (state_nxt == A_EH) || (state_nxt == D_EH);
            lcd_rs   <= phase_d ? ctrl_nxt[0] : 1'b0;
            lcd_data <= phase_a ? {1'b1, addr_nxt} : (phase_d ? data_nxt : 8'h00);
            if ((state_nxt == DONE) && (state != DONE))
                status <= status + 8'd1;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_exec.sv
// Directed bench for lcd_cmd_exec with short timing parameters.
module tb_lcd_cmd_exec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Address_in = 8'h00;
    logic [7:0] Control_in = 8'h00;
    logic [7:0] Data_in = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       busy, overrun, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] status, lcd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int rw_bad  = 0;
    logic [7:0] exp_status = 8'h00;

    int         bc, np, estart, w0;
    logic       rs0, rs1, prev_e;
    logic [7:0] d0, d1, st_pre, st_last;
    bit         tmo;

    lcd_cmd_exec #(.T_SU(1), .T_EH(2), .T_HD(1), .T_EX(4), .T_EXL(8)) dut (
        .clk(clk), .rst_n(rst_n), .Address_in(Address_in), .Control_in(Control_in),
        .Data_in(Data_in), .cmd_valid(cmd_valid), .busy(busy), .status(status),
        .overrun(overrun), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    // Issues one command from a negedge and records the bus until busy drops.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d);
        Address_in = a; Control_in = c; Data_in = d; cmd_valid = 1'b1;
        bc = 0; np = 0; estart = -1; w0 = 0; rs0 = 1'bx; rs1 = 1'bx;
        d0 = 8'hxx; d1 = 8'hxx; prev_e = 1'b0; st_last = status; st_pre = status;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        Address_in = 8'($urandom); Control_in = 8'($urandom); Data_in = 8'($urandom);
        tmo = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_bad++;
            if (busy !== 1'b1) begin tmo = 1'b0; break; end
            st_pre = st_last; st_last = status;
            if (lcd_e === 1'b1 && !prev_e) begin
                np++;
                if (np == 1) begin estart = bc; rs0 = lcd_rs; d0 = lcd_data; end
                else if (np == 2) begin rs1 = lcd_rs; d1 = lcd_data; end
            end
            if (lcd_e === 1'b1 && np == 1) w0++;
            prev_e = lcd_e; bc++;
        end
        n_tests++;
        if (tmo) begin n_fail++; $display("FAIL cmd_timeout: busy still high after 300 cycles"); end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1; Address_in = 8'h85; Control_in = 8'h00; Data_in = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, overrun, lcd_e, lcd_rs, lcd_rw, lcd_data} !== 13'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {busy, overrun, lcd_e, lcd_rs, lcd_rw, lcd_data});
        end
        n_tests++;
        if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", status); end
        // First edge with rst_n high accepts a skip-only command.
        Address_in = 8'h00; Control_in = 8'h04; rst_n = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, status} !== {1'b1, 8'h01}) begin
            n_fail++; $display("FAIL first_accept: got busy=%b status=%h want busy=1 status=01", busy, status);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL first_accept_idle: got busy=%b want 0", busy); end
        exp_status = 8'h01;
    endtask

    task automatic test_data_only();
        run_cmd(8'h00, 8'h01, 8'h41);
        n_tests++;
        if (bc !== 9) begin n_fail++; $display("FAIL s1_busy_cycles: got %0d want 9", bc); end
        n_tests++;
        if ({np, estart, w0} !== {32'd1, 32'd1, 32'd2}) begin
            n_fail++; $display("FAIL s1_e_pulse: got n=%0d start=%0d width=%0d want 1,1,2", np, estart, w0);
        end
        n_tests++;
        if ({rs0, d0} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL s1_bus: got rs=%b data=%h want rs=1 data=41", rs0, d0); end
        n_tests++;
        if ({st_pre, st_last} !== {exp_status, exp_status + 8'd1}) begin
            n_fail++; $display("FAIL s1_status: got %h->%h want %h->%h", st_pre, st_last, exp_status, exp_status + 8'd1);
        end
        n_tests++;
        if ({lcd_e, lcd_rs, lcd_data} !== 10'h0) begin
            n_fail++; $display("FAIL s1_idle_bus: got e=%b rs=%b data=%h want 0", lcd_e, lcd_rs, lcd_data);
        end
        exp_status = exp_status + 8'd1;
    endtask

    task automatic test_addr_data();
        run_cmd(8'h85, 8'h00, 8'h0C);
        n_tests++;
        if (bc !== 17) begin n_fail++; $display("FAIL s2_busy_cycles: got %0d want 17", bc); end
        n_tests++;
        if ({np, w0} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL s2_pulses: got n=%0d width=%0d want 2,2", np, w0); end
        n_tests++;
        if ({rs0, d0, rs1, d1} !== {1'b0, 8'h85, 1'b0, 8'h0C}) begin
            n_fail++; $display("FAIL s2_bus: got %b/%h %b/%h want 0/85 0/0c", rs0, d0, rs1, d1);
        end
        n_tests++;
        if (st_last !== exp_status + 8'd1) begin n_fail++; $display("FAIL s2_status: got %h want %h", st_last, exp_status + 8'd1); end
        exp_status = exp_status + 8'd1;
    endtask

    task automatic test_long_wait();
        run_cmd(8'h00, 8'h02, 8'h01);
        n_tests++;
        if ({bc, np} !== {32'd13, 32'd1}) begin n_fail++; $display("FAIL s3_long: got busy=%0d pulses=%0d want 13,1", bc, np); end
        n_tests++;
        if ({rs0, d0} !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL s3_bus: got rs=%b data=%h want 0/01", rs0, d0); end
        exp_status = exp_status + 8'd1;
    endtask

    task automatic test_skip();
        run_cmd(8'h00, 8'h04, 8'hAA);
        n_tests++;
        if ({bc, np} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL s4_skip: got busy=%0d pulses=%0d want 1,0", bc, np); end
        n_tests++;
        if ({st_pre, st_last} !== {exp_status, exp_status + 8'd1}) begin
            n_fail++; $display("FAIL s4_status: got %h->%h want %h->%h", st_pre, st_last, exp_status, exp_status + 8'd1);
        end
        exp_status = exp_status + 8'd1;
    endtask

    task automatic test_overrun();
        bit gone;
        Address_in = 8'h00; Control_in = 8'h01; Data_in = 8'h41; cmd_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        Address_in = 8'h85; Control_in = 8'h04; Data_in = 8'h99; cmd_valid = 1'b1;
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_quiet: got %b want 0", overrun); end
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({overrun, lcd_e, lcd_rs, lcd_data} !== {1'b1, 1'b1, 1'b1, 8'h41}) begin
            n_fail++; $display("FAIL ovr_pulse: got ovr=%b e=%b rs=%b data=%h want 1,1,1,41", overrun, lcd_e, lcd_rs, lcd_data);
        end
        @(negedge clk);
        n_tests++;
        if ({overrun, lcd_rs, lcd_data} !== {1'b0, 1'b1, 8'h41}) begin
            n_fail++; $display("FAIL ovr_single: got ovr=%b rs=%b data=%h want 0,1,41", overrun, lcd_rs, lcd_data);
        end
        gone = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin gone = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if ({gone, busy, status} !== {1'b1, 1'b0, exp_status + 8'd1}) begin
            n_fail++; $display("FAIL ovr_dropped: got done=%b busy=%b status=%h want 1,0,%h", gone, busy, status, exp_status + 8'd1);
        end
        exp_status = exp_status + 8'd1;
    endtask

    task automatic test_back_to_back();
        run_cmd(8'h00, 8'h01, 8'h41);
        run_cmd(8'h00, 8'h01, 8'h42);
        n_tests++;
        if ({bc, np, rs0, d0} !== {32'd9, 32'd1, 1'b1, 8'h42}) begin
            n_fail++; $display("FAIL b2b_second: got busy=%0d pulses=%0d rs=%b data=%h want 9,1,1,42", bc, np, rs0, d0);
        end
        n_tests++;
        if (status !== exp_status + 8'd2) begin n_fail++; $display("FAIL b2b_status: got %h want %h", status, exp_status + 8'd2); end
        exp_status = exp_status + 8'd2;
    endtask

    task automatic test_reset_mid();
        bit seen;
        Address_in = 8'h00; Control_in = 8'h01; Data_in = 8'h41; cmd_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_e === 1'b1) begin seen = 1'b1; break; end
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({seen, lcd_e, busy, status} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL rst_mid: got seen=%b e=%b busy=%b status=%h want 1,0,0,00", seen, lcd_e, busy, status);
        end
        rst_n = 1'b1;
        exp_status = 8'h00;
        run_cmd(8'h00, 8'h01, 8'h41);
        n_tests++;
        if ({bc, np, st_last} !== {32'd9, 32'd1, 8'h01}) begin
            n_fail++; $display("FAIL rst_mid_recover: got busy=%0d pulses=%0d status=%h want 9,1,01", bc, np, st_last);
        end
        exp_status = 8'h01;
    endtask

    task automatic test_status_wrap();
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_status = 8'h00;
        for (int k = 0; k < 256; k++) begin
            run_cmd(8'h00, 8'h04, 8'h00);
            n_tests++;
            if ({bc, np, st_pre, st_last} !== {32'd1, 32'd0, exp_status, exp_status + 8'd1}) begin
                n_fail++;
                $display("FAIL wrap_step %0d: got busy=%0d pulses=%0d status %h->%h want 1,0,%h->%h",
                         k, bc, np, st_pre, st_last, exp_status, exp_status + 8'd1);
            end
            exp_status = exp_status + 8'd1;
        end
        n_tests++;
        if (status !== 8'h00) begin n_fail++; $display("FAIL wrap_final: got %h want 00", status); end
    endtask

    initial begin
        test_reset();
        test_data_only();
        test_addr_data();
        test_long_wait();
        test_skip();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_status_wrap();
        n_tests++;
        if (rw_bad !== 0) begin n_fail++; $display("FAIL lcd_rw: got %0d cycles high want 0", rw_bad); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
